// File: rtl/print_pkg.sv
// Shared types and constants for the print engine: state encoding, line
// terminator characters and default widths.
`default_nettype none

package print_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         DEF_ADDR_W = 7;
  localparam int         DEF_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/print_engine.sv
// Print command responder: streams a character-buffer range (optionally
// followed by CR/LF) or a single bypass byte to a UART over valid/ready.
`default_nettype none

module print_engine
  import print_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [ADDR_W-1:0] addr_start_i,
  input  logic [ADDR_W-1:0] addr_end_i,
  input  logic              en_i,
  input  logic              bypass_i,
  input  logic [DATA_W-1:0] bypass_data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                byp_q, byp_d;
  logic                done_q, done_d;
  logic                hs;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      last_q    <= '0;
      tx_data_q <= '0;
      byp_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      byp_q     <= byp_d;
      done_q    <= done_d;
    end
  end

  // Valid is a pure function of state, so it never depends on tx_ready_i.
  assign tx_valid_o = (state_q == ST_SEND) || (state_q == ST_CR) || (state_q == ST_LF);
  assign ready_o    = (state_q == ST_IDLE);
  assign hs         = tx_valid_o & tx_ready_i;
  assign mem_addr_o = cur_q;
  assign tx_data_o  = tx_data_q;
  assign done_o     = done_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    byp_d     = byp_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          if (bypass_i) begin
            tx_data_d = bypass_data_i;
            byp_d     = 1'b1;
            state_d   = ST_SEND;
          end else begin
            cur_d   = addr_start_i;
            last_d  = addr_end_i;
            byp_d   = 1'b0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        tx_data_d = mem_data_i;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          if (byp_q) begin
            byp_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cur_q == last_q) begin
            if (APPEND_CRLF) begin
              tx_data_d = DATA_W'(ASCII_CR);
              state_d   = ST_CR;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_CR: begin
        if (hs) begin
          tx_data_d = DATA_W'(ASCII_LF);
          state_d   = ST_LF;
        end
      end
      ST_LF: begin
        if (hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
